// File: rtl/sr_piso_param.sv
// Handshaked parallel-in/serial-out shifter with a one-word holding buffer and strobe-paced output.
// Optional even-parity trailer bit is compiled in with SR_PISO_PARITY_EN.
module sr_piso_param #(
   parameter int   WIDTH      = 8,
   parameter logic IDLE_LEVEL = 1'b0,
   parameter int   CW         = $clog2(WIDTH + 1)   // derived; do not override
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [WIDTH-1:0] pin,
   input  logic             pin_valid,
   output logic             pin_ready,
   input  logic             lsb_first,
   input  logic             shift_en,
   output logic             sout,
   output logic             sout_valid,
   output logic             busy,
   output logic             frame_done,
   output logic [CW-1:0]    bit_cnt
);

   localparam logic [1:0] IDLE   = 2'd0;
   localparam logic [1:0] SHIFT  = 2'd1;
`ifdef SR_PISO_PARITY_EN
   localparam logic [1:0] PARITY = 2'd2;
`endif
   localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

   logic [1:0]       state;
   logic [WIDTH-1:0] hold_word;
   logic             hold_lsb;
   logic             hold_full;
   logic [WIDTH-1:0] shreg;
   logic             lsb_mode;
`ifdef SR_PISO_PARITY_EN
   logic             par_bit;
`endif

   logic last_bit;
   logic frame_end;
   logic load;

   always_comb begin
      last_bit = (state == SHIFT) && shift_en && (bit_cnt == LAST);
`ifdef SR_PISO_PARITY_EN
      frame_end = (state == PARITY) && shift_en;
`else
      frame_end = last_bit;
`endif
      // Buffer moves to the shift register from IDLE, or directly at a frame end for gapless frames.
      load = hold_full && ((state == IDLE) || frame_end);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= IDLE;
         hold_word  <= '0;
         hold_lsb   <= 1'b0;
         hold_full  <= 1'b0;
         shreg      <= '0;
         lsb_mode   <= 1'b0;
         bit_cnt    <= '0;
         frame_done <= 1'b0;
`ifdef SR_PISO_PARITY_EN
         par_bit    <= 1'b0;
`endif
      end else begin
         frame_done <= frame_end;

         if (pin_valid && !hold_full) begin
            hold_word <= pin;
            hold_lsb  <= lsb_first;
            hold_full <= 1'b1;
         end else if (load) begin
            hold_full <= 1'b0;
         end

         if (load) begin
            shreg    <= hold_word;
            lsb_mode <= hold_lsb;
            bit_cnt  <= '0;
            state    <= SHIFT;
`ifdef SR_PISO_PARITY_EN
            par_bit  <= ^hold_word;
`endif
         end else if (frame_end) begin
            shreg   <= '0;
            bit_cnt <= '0;
            state   <= IDLE;
         end else if ((state == SHIFT) && shift_en) begin
            shreg   <= lsb_mode ? (shreg >> 1) : (shreg << 1);
            bit_cnt <= bit_cnt + CW'(1);
`ifdef SR_PISO_PARITY_EN
            if (last_bit) state <= PARITY;
`endif
         end
      end
   end

   always_comb begin
      pin_ready  = !hold_full;
      busy       = (state != IDLE) || hold_full;
      sout_valid = (state != IDLE);
      sout       = IDLE_LEVEL;
      case (state)
         SHIFT:   sout = lsb_mode ? shreg[0] : shreg[WIDTH-1];
`ifdef SR_PISO_PARITY_EN
         PARITY:  sout = par_bit;
`endif
         default: sout = IDLE_LEVEL;
      endcase
   end

endmodule

// File: tb/tb_sr_piso_param.sv
// Self-checking bench for sr_piso_param: directed frames plus a randomized stream against a bit-queue model.
// Expected frame length follows SR_PISO_PARITY_EN.
module tb_sr_piso_param;

   localparam int W  = 8;
   localparam int CW = $clog2(W + 1);
   localparam logic IDLE_LVL = 1'b1;
`ifdef SR_PISO_PARITY_EN
   localparam int FL = W + 1;
`else
   localparam int FL = W;
`endif

   logic          clk = 1'b0;
   logic          rst_n = 1'b1;
   logic [W-1:0]  pin = '0;
   logic          pin_valid = 1'b0;
   logic          pin_ready;
   logic          lsb_first = 1'b0;
   logic          shift_en = 1'b0;
   logic          sout;
   logic          sout_valid;
   logic          busy;
   logic          frame_done;
   logic [CW-1:0] bit_cnt;

   int unsigned n_cmp = 0;
   int unsigned n_fail = 0;

   sr_piso_param #(.WIDTH(W), .IDLE_LEVEL(IDLE_LVL)) dut (
      .clk(clk), .rst_n(rst_n), .pin(pin), .pin_valid(pin_valid), .pin_ready(pin_ready),
      .lsb_first(lsb_first), .shift_en(shift_en), .sout(sout), .sout_valid(sout_valid),
      .busy(busy), .frame_done(frame_done), .bit_cnt(bit_cnt)
   );

   always #5 clk = ~clk;

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   // Bit k of a frame: data bits in the chosen order, then the even-parity trailer.
   function automatic logic exp_bit(input logic [W-1:0] w, input logic lsb, input int k);
      if (k >= W) return ^w;
      return lsb ? w[k] : w[W-1-k];
   endfunction

   task automatic test_reset;
      rst_n = 1'b1;
      #2 rst_n = 1'b0;
      #1;
      n_cmp++; if ({pin_ready, sout, sout_valid, busy, frame_done, bit_cnt} !== {1'b1, IDLE_LVL, 3'b000, CW'(0)}) begin
         n_fail++; $display("FAIL reset_initial got %b want %b", {pin_ready, sout, sout_valid, busy, frame_done, bit_cnt}, {1'b1, IDLE_LVL, 3'b000, CW'(0)});
      end
      tick; tick;
      rst_n = 1'b1;
      // Start 8'hC1 and abort it at bit 3 with a second word waiting in the buffer.
      pin = 8'hC1; lsb_first = 1'b0; pin_valid = 1'b1; shift_en = 1'b1;
      tick;
      pin_valid = 1'b0;
      tick;
      pin = 8'h5A; pin_valid = 1'b1;
      tick;
      pin_valid = 1'b0;
      tick; tick;
      n_cmp++; if (bit_cnt !== CW'(3) || busy !== 1'b1) begin
         n_fail++; $display("FAIL reset_pre bit_cnt=%0d busy=%b want 3/1", bit_cnt, busy);
      end
      rst_n = 1'b0;
      #1;
      n_cmp++; if ({pin_ready, sout, sout_valid, busy, frame_done, bit_cnt} !== {1'b1, IDLE_LVL, 3'b000, CW'(0)}) begin
         n_fail++; $display("FAIL reset_async got %b want %b", {pin_ready, sout, sout_valid, busy, frame_done, bit_cnt}, {1'b1, IDLE_LVL, 3'b000, CW'(0)});
      end
      tick; tick;
      rst_n = 1'b1;
      tick; tick;
      n_cmp++; if (busy !== 1'b0 || frame_done !== 1'b0 || sout_valid !== 1'b0) begin
         n_fail++; $display("FAIL reset_discard busy=%b fd=%b sv=%b want 0/0/0", busy, frame_done, sout_valid);
      end
      shift_en = 1'b0;
   endtask

   // One frame from IDLE; strobe high on every period-th cycle of the frame.
   task automatic run_frame(input logic [W-1:0] w, input logic lsb, input int period, input string tag);
      int k = 0;
      int cyc = 0;
      bit done = 0;
      pin = w; lsb_first = lsb; pin_valid = 1'b1; shift_en = 1'b1;
      tick;
      pin_valid = 1'b0; lsb_first = ~lsb; pin = ~w;
      n_cmp++; if ({pin_ready, busy, sout_valid, sout} !== {1'b0, 1'b1, 1'b0, IDLE_LVL}) begin
         n_fail++; $display("FAIL %s_held got %b want %b", tag, {pin_ready, busy, sout_valid, sout}, {1'b0, 1'b1, 1'b0, IDLE_LVL});
      end
      tick;
      while (!done && cyc < FL * period + 4) begin
         n_cmp++; if ({sout_valid, sout, frame_done} !== {1'b1, exp_bit(w, lsb, k), 1'b0} || bit_cnt !== CW'(k)) begin
            n_fail++; $display("FAIL %s_bit%0d got sv=%b sout=%b fd=%b cnt=%0d want 1/%b/0/%0d", tag, k, sout_valid, sout, frame_done, bit_cnt, exp_bit(w, lsb, k), k);
         end
         shift_en = ((cyc % period) == period - 1);
         tick;
         cyc++;
         if (shift_en) k++;
         if (frame_done) done = 1;
      end
      n_cmp++; if (!done || cyc != FL * period || k != FL) begin
         n_fail++; $display("FAIL %s_length done=%0d cycles=%0d strobes=%0d want 1/%0d/%0d", tag, done, cyc, k, FL * period, FL);
      end
      n_cmp++; if ({sout_valid, sout, pin_ready} !== {1'b0, IDLE_LVL, 1'b1}) begin
         n_fail++; $display("FAIL %s_end got %b want %b", tag, {sout_valid, sout, pin_ready}, {1'b0, IDLE_LVL, 1'b1});
      end
      shift_en = 1'b0;
      tick;
      n_cmp++; if (frame_done !== 1'b0 || busy !== 1'b0) begin
         n_fail++; $display("FAIL %s_pulse fd=%b busy=%b want 0/0", tag, frame_done, busy);
      end
   endtask

   task automatic test_msb_first;
      run_frame(8'hC1, 1'b0, 1, "msb");
   endtask

   task automatic test_lsb_first;
      run_frame(8'hC1, 1'b1, 1, "lsb");
   endtask

   task automatic test_strobe_gating;
      run_frame(8'hC1, 1'b0, 3, "strobe");
   endtask

   task automatic test_back_to_back;
      int pulses = 0;
      logic eb;
      logic exp_rdy;
      pin = 8'hC1; lsb_first = 1'b0; pin_valid = 1'b1; shift_en = 1'b0;
      tick;
      pin_valid = 1'b0;
      tick;
      for (int idx = 0; idx < 2 * FL; idx++) begin
         eb = (idx < FL) ? exp_bit(8'hC1, 1'b0, idx) : exp_bit(8'h0F, 1'b1, idx - FL);
         exp_rdy = (idx <= 1 || idx >= FL);
         n_cmp++; if ({sout_valid, sout, pin_ready} !== {1'b1, eb, exp_rdy} || bit_cnt !== CW'(idx % FL)) begin
            n_fail++; $display("FAIL b2b_bit%0d got sv=%b sout=%b rdy=%b cnt=%0d want 1/%b/%b/%0d", idx, sout_valid, sout, pin_ready, bit_cnt, eb, exp_rdy, idx % FL);
         end
         shift_en = 1'b1;
         if (idx == 1) begin
            pin = 8'h0F; lsb_first = 1'b1; pin_valid = 1'b1;
         end else begin
            pin_valid = 1'b0;
         end
         tick;
         if (frame_done) pulses++;
         n_cmp++; if (frame_done !== (idx == FL - 1 || idx == 2 * FL - 1)) begin
            n_fail++; $display("FAIL b2b_done%0d got %b want %b", idx, frame_done, (idx == FL - 1 || idx == 2 * FL - 1));
         end
      end
      n_cmp++; if (pulses != 2 || sout_valid !== 1'b0) begin
         n_fail++; $display("FAIL b2b_total pulses=%0d sv=%b want 2/0", pulses, sout_valid);
      end
      shift_en = 1'b0; pin_valid = 1'b0;
      tick;
   endtask

   task automatic test_random;
      logic exp_q[$];
      int   idx_q[$];
      int   accepted = 0;
      int   finished = 0;
      int   guard = 0;
      logic [W-1:0] w;
      logic lb;
      logic eb;
      int   ei;
      for (int c = 0; c < 800; c++) begin
         if (frame_done) finished++;
         w = W'($urandom);
         lb = 1'($urandom);
         pin = w; lsb_first = lb;
         pin_valid = ($urandom_range(0, 2) == 0);
         shift_en = 1'($urandom);
         if (sout_valid && shift_en) begin
            if (exp_q.size() == 0) begin
               n_cmp++; n_fail++; $display("FAIL rand_extra_bit got sout=%b want no frame", sout);
            end else begin
               eb = exp_q.pop_front(); ei = idx_q.pop_front();
               n_cmp++; if (sout !== eb || bit_cnt !== CW'(ei)) begin
                  n_fail++; $display("FAIL rand_bit got sout=%b cnt=%0d want %b/%0d", sout, bit_cnt, eb, ei);
               end
            end
         end else if (!sout_valid) begin
            n_cmp++; if (sout !== IDLE_LVL) begin
               n_fail++; $display("FAIL rand_idle_level got %b want %b", sout, IDLE_LVL);
            end
         end
         if (pin_valid && pin_ready) begin
            accepted++;
            for (int k = 0; k < FL; k++) begin
               exp_q.push_back(exp_bit(w, lb, k)); idx_q.push_back(k);
            end
         end
         tick;
      end
      pin_valid = 1'b0; shift_en = 1'b1;
      while (busy && guard < 300) begin
         if (frame_done) finished++;
         if (sout_valid) begin
            if (exp_q.size() == 0) begin
               n_cmp++; n_fail++; $display("FAIL rand_drain_extra got sout=%b want no frame", sout);
            end else begin
               eb = exp_q.pop_front(); ei = idx_q.pop_front();
               n_cmp++; if (sout !== eb || bit_cnt !== CW'(ei)) begin
                  n_fail++; $display("FAIL rand_drain_bit got sout=%b cnt=%0d want %b/%0d", sout, bit_cnt, eb, ei);
               end
            end
         end
         tick;
         guard++;
      end
      if (frame_done) finished++;
      n_cmp++; if (busy !== 1'b0 || exp_q.size() != 0 || finished != accepted) begin
         n_fail++; $display("FAIL rand_final busy=%b left=%0d frames=%0d want 0/0/%0d", busy, exp_q.size(), finished, accepted);
      end
      shift_en = 1'b0;
      tick;
   endtask

   initial begin
      test_reset;
      test_msb_first;
      test_lsb_first;
      test_back_to_back;
      test_strobe_gating;
      test_random;
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule

// File: doc/sr_piso_param.md
# sr_piso_param

Parametrised, handshaked parallel-in/serial-out shifter. It accepts WIDTH-bit words through a valid/ready port into a one-word holding buffer, then serialises each word MSB-first or LSB-first at a rate set by a bit strobe. Back-to-back frames have no idle gap, and an optional parity bit can be appended. It is the general serialiser for the team's serial-link and test-pattern paths, replacing the fixed 4-bit PISO.

## Interface
Parameters:
- WIDTH, default 8: word width; legal values are 2 or more.
- IDLE_LEVEL, default 1'b0: level driven on sout when no frame is active.
- CW, derived as $clog2(WIDTH+1): width of bit_cnt; not for override.

Ports:
- clk  in  1  single clock; all state changes on its rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- pin  in  WIDTH  parallel word.
- pin_valid  in  1  pin and lsb_first are valid.
- pin_ready  out  1  holding buffer empty; a word transfers when pin_valid and pin_ready are high at an edge.
- lsb_first  in  1  bit order of the word; sampled with the word.
- shift_en  in  1  bit strobe; each edge where it is high advances one bit.
- sout  out  1  serial data.
- sout_valid  out  1  sout carries a frame bit.
- busy  out  1  high when state is not IDLE or the buffer holds a word.
- frame_done  out  1  one-cycle pulse per completed frame.
- bit_cnt  out  CW  index of the bit currently on sout.

## Operation
Holding buffer:
- Contents: hold_word, hold_lsb, hold_full.
- pin_ready = !hold_full, taken straight from the register.
- An accepted word sets hold_full.

FSM states and transitions:
- IDLE, with hold_full set: move the buffer into the shift register and clear hold_full. Next state is SHIFT, bit_cnt = 0.
- SHIFT: the output bit is shreg[WIDTH-1] in MSB mode and shreg[0] in LSB mode.
- SHIFT, on an edge with shift_en high: shift toward the output end, zero-filling the vacated bit, and increment bit_cnt.
- SHIFT, last bit (bit_cnt == WIDTH-1 with shift_en high): go to PARITY if the parity feature is compiled in. Otherwise end the frame.
- PARITY: sout = parity bit; on shift_en, end the frame.

Frame end:
- Pulse frame_done.
- If hold_full is set at that edge, load the buffer directly, stay in SHIFT and reset bit_cnt to 0, so there is no gap between frames.
- Otherwise go to IDLE.

Ignored conditions:
- shift_en is ignored in IDLE and on the buffer-transfer edge.
- pin_valid is ignored while pin_ready is low.
- lsb_first changes between accepts have no effect.

Outputs by state:
- sout = IDLE_LEVEL and sout_valid = 0 in IDLE.
- sout_valid = 1 in SHIFT and PARITY.

## Timing
- Reset values (rst_n low, applied immediately, asynchronous):
  - State: IDLE, with hold_full = 0 and shreg = 0.
  - Outputs: pin_ready = 1, sout = IDLE_LEVEL, sout_valid = 0, busy = 0, frame_done = 0, bit_cnt = 0.
- Reset mid-frame aborts the frame and discards the buffer; frame_done does not pulse.
- Latency from an accept at edge N:
  - Frame starts: hold_full is high after N, the buffer transfers at N+1, and bit 0 is on sout after N+1.
  - Frame ends: frame_done is high for the single cycle after the edge that consumes the final bit (data or parity).
- With shift_en held high, a frame lasts WIDTH cycles, or WIDTH+1 with parity.
- pin_ready drops for one cycle after an accept made in IDLE. During SHIFT it stays low from the accept until the frame-end edge that empties the buffer.
- sout, sout_valid, busy and bit_cnt come from registers only; they have no combinational path from inputs.

## Configuration
- Macro: SR_PISO_PARITY_EN.
- Defined:
  - An even-parity bit (XOR of the word, computed at load) is sent after the last data bit.
  - The PARITY state exists.
  - bit_cnt reads WIDTH during the parity bit.
- Undefined:
  - No PARITY state; frames are exactly WIDTH bits.
  - The parity logic is absent.

## Test plan
- Reset: pull rst_n low mid-frame (bit 3 of 8'hC1) -> all outputs take their reset values without waiting for a clock; the next accept starts cleanly at bit_cnt 0.
- MSB-first: WIDTH=8, pin=8'hC1, lsb_first=0, shift_en=1 -> sout = 1,1,0,0,0,0,0,1 over 8 cycles with bit_cnt 0..7; frame_done pulses once, then IDLE.
- LSB-first: pin=8'hC1, lsb_first=1 -> sout = 1,0,0,0,0,0,1,1.
- Back-to-back: 8'hC1 (MSB mode), then 8'h0F (LSB mode) accepted during the first frame -> 16 contiguous valid bits, 1,1,0,0,0,0,0,1 then 1,1,1,1,0,0,0,0; pin_ready is low from the second accept until the first frame's last edge; frame_done pulses twice.
- Strobe gating: shift_en high every third cycle -> each bit is held 3 cycles, the frame lasts 24 cycles, and bit_cnt advances only on strobes.
- Parity: with SR_PISO_PARITY_EN defined, 8'hC1 gives a ninth bit of 1 (three ones, even parity) and frame_done after 9 strobes; without the macro, frame_done comes after 8 strobes.
